mem_req_arbiter: RTL and testbench

Shares one SRAM-like memory port between the instruction-fetch requester (IF) and the data requester (EX load/store).
- Registers the winning request in a one-entry request buffer and issues it to memory.
- Tracks in-flight transactions in an in-order response queue and routes each memory response back to its originator.
- Drops instruction responses invalidated by an exception or ertn flush.
- Sits between the IF/EX units and the memory bridge.

---
 rtl/mem_req_arbiter_pkg.sv | 18 +
 rtl/mem_req_arbiter_if.sv | 35 +++
 rtl/mem_req_arbiter_resp_order_fifo.sv | 70 +++++++
 rtl/mem_req_arbiter.sv | 111 +++++++++++
 tb/tb_mem_req_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// rtl/mem_req_arbiter_pkg.sv - shared source IDs and size encodings for the memory request arbiter
package mem_req_arbiter_pkg;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Width of the {wr, size, wstrb, addr, wdata} request payload
    function automatic int req_bus_size(input int addr_w);
        return 1 + 2 + 4 + addr_w + 32;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// rtl/mem_req_arbiter_if.sv - SRAM-like request/response bus with requester and responder views
interface mem_req_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [3:0]        wstrb;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [31:0]       rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

    // Instruction fetch is read-only word access, so only req/addr travel downstream
    modport fetch_master (
        output req, addr,
        input  addr_ok, data_ok, rdata
    );

    modport fetch_slave (
        input  req, addr,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/mem_req_arbiter_resp_order_fifo.sv
// rtl/mem_req_arbiter_resp_order_fifo.sv - in-order {src, discard} tracker for outstanding memory transactions
module resp_order_fifo
    import mem_req_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic push,
    input  src_e push_src,
    input  logic push_discard,
    input  logic pop,
    output logic full,
    output logic empty,
    output src_e head_src,
    output logic head_discard
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    src_e          src_q  [DEPTH];
    logic          disc_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign do_push      = push && !full;
    assign do_pop       = pop && !empty;
    assign head_src     = src_q[rd_ptr];
    assign head_discard = disc_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                src_q[i]  <= SRC_INST;
                disc_q[i] <= 1'b0;
            end
        end else begin
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (src_q[i] == SRC_INST) disc_q[i] <= 1'b1;
                end
            end
            // The pushed entry already folds in this cycle's flush, so it overrides the loop above
            if (do_push) begin
                src_q[wr_ptr]  <= push_src;
                disc_q[wr_ptr] <= push_discard;
                wr_ptr         <= next_ptr(wr_ptr);
            end
            if (do_pop) rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - shares one memory port between instruction fetch and data access with in-order response routing
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int ADDR_W      = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    mem_req_arbiter_if.fetch_slave  inst,
    mem_req_arbiter_if.slave        data,
    mem_req_arbiter_if.master       mem
);
    logic              rb_valid;
    src_e              rb_src;
    logic              rb_discard;
    logic              rb_wr;
    logic [1:0]        rb_size;
    logic [3:0]        rb_wstrb;
    logic [ADDR_W-1:0] rb_addr;
    logic [31:0]       rb_wdata;

    logic q_full;
    logic q_empty;
    src_e head_src;
    logic head_discard;

    logic mem_req_int;
    logic issue;
    logic slot_free;
    logic data_acc;
    logic inst_acc;
    logic push_discard;
    logic resp_valid;

    assign mem_req_int  = !reset && rb_valid && !q_full;
    assign issue        = mem_req_int && mem.addr_ok;
    assign slot_free    = !rb_valid || issue;
    assign data_acc     = !reset && slot_free && data.req;
    assign inst_acc     = !reset && slot_free && inst.req && !data.req && !flush;
    assign push_discard = rb_discard || (flush && rb_src == SRC_INST);

    assign inst.addr_ok = inst_acc;
    assign data.addr_ok = data_acc;

    assign mem.req   = mem_req_int;
    assign mem.wr    = rb_wr;
    assign mem.size  = rb_size;
    assign mem.wstrb = rb_wstrb;
    assign mem.addr  = rb_addr;
    assign mem.wdata = rb_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            rb_valid   <= 1'b0;
            rb_src     <= SRC_INST;
            rb_discard <= 1'b0;
            rb_wr      <= 1'b0;
            rb_size    <= 2'd0;
            rb_wstrb   <= 4'd0;
            rb_addr    <= '0;
            rb_wdata   <= 32'd0;
        end else if (data_acc) begin
            rb_valid   <= 1'b1;
            rb_src     <= SRC_DATA;
            rb_discard <= 1'b0;
            rb_wr      <= data.wr;
            rb_size    <= data.size;
            rb_wstrb   <= data.wr ? data.wstrb : 4'd0;
            rb_addr    <= data.addr;
            rb_wdata   <= data.wdata;
        end else if (inst_acc) begin
            rb_valid   <= 1'b1;
            rb_src     <= SRC_INST;
            rb_discard <= 1'b0;
            rb_wr      <= 1'b0;
            rb_size    <= SZ_WORD;
            rb_wstrb   <= 4'd0;
            rb_addr    <= inst.addr;
            rb_wdata   <= 32'd0;
        end else if (issue) begin
            rb_valid   <= 1'b0;
        end else if (flush && rb_src == SRC_INST) begin
            // A flushed fetch still has to be issued; only its response is dropped
            rb_discard <= 1'b1;
        end
    end

    resp_order_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_resp_order_fifo (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .push         (issue),
        .push_src     (rb_src),
        .push_discard (push_discard),
        .pop          (mem.data_ok && !reset),
        .full         (q_full),
        .empty        (q_empty),
        .head_src     (head_src),
        .head_discard (head_discard)
    );

    assign resp_valid   = !reset && mem.data_ok && !q_empty;
    assign data.data_ok = resp_valid && head_src == SRC_DATA;
    assign inst.data_ok = resp_valid && head_src == SRC_INST && !head_discard && !flush;
    assign data.rdata   = data.data_ok ? mem.rdata : 32'd0;
    assign inst.rdata   = inst.data_ok ? mem.rdata : 32'd0;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - directed self-checking bench for mem_req_arbiter
module tb_mem_req_arbiter;
    logic clk;
    logic reset;
    logic flush;
    int   pass_cnt;
    int   total_cnt;

    mem_req_arbiter_if #(.ADDR_W(32)) inst_bus ();
    mem_req_arbiter_if #(.ADDR_W(32)) data_bus ();
    mem_req_arbiter_if #(.ADDR_W(32)) mem_bus ();

    mem_req_arbiter #(
        .OUTSTANDING (2),
        .ADDR_W      (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .inst  (inst_bus.fetch_slave),
        .data  (data_bus.slave),
        .mem   (mem_bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush            = 1'b0;
        inst_bus.req     = 1'b0;
        inst_bus.addr    = 32'd0;
        inst_bus.wr      = 1'b0;
        inst_bus.size    = 2'd0;
        inst_bus.wstrb   = 4'd0;
        inst_bus.wdata   = 32'd0;
        data_bus.req     = 1'b0;
        data_bus.wr      = 1'b0;
        data_bus.size    = 2'd0;
        data_bus.wstrb   = 4'd0;
        data_bus.addr    = 32'd0;
        data_bus.wdata   = 32'd0;
        mem_bus.addr_ok  = 1'b0;
        mem_bus.data_ok  = 1'b0;
        mem_bus.rdata    = 32'd0;
    endtask

    task automatic data_load(input logic [31:0] a);
        data_bus.req   = 1'b1;
        data_bus.wr    = 1'b0;
        data_bus.size  = 2'd2;
        data_bus.wstrb = 4'hF;
        data_bus.addr  = a;
        data_bus.wdata = 32'd0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        inst_bus.req = 1'b1;
        data_bus.req = 1'b1;
        mem_bus.data_ok = 1'b1;
        to_neg();
        total_cnt++; if (inst_bus.addr_ok !== 1'b0) $display("FAIL reset_inst_addr_ok got %b exp 0", inst_bus.addr_ok); else pass_cnt++;
        total_cnt++; if (data_bus.addr_ok !== 1'b0) $display("FAIL reset_data_addr_ok got %b exp 0", data_bus.addr_ok); else pass_cnt++;
        total_cnt++; if (mem_bus.req !== 1'b0) $display("FAIL reset_mem_req got %b exp 0", mem_bus.req); else pass_cnt++;
        total_cnt++; if (data_bus.data_ok !== 1'b0 || inst_bus.data_ok !== 1'b0) $display("FAIL reset_data_ok got %b%b exp 00", inst_bus.data_ok, data_bus.data_ok); else pass_cnt++;
        next_cyc();
        next_cyc();
        clear_inputs();
        reset = 1'b0;
        to_neg();
        total_cnt++; if (mem_bus.req !== 1'b0 || mem_bus.addr !== 32'd0 || mem_bus.wstrb !== 4'd0) $display("FAIL post_reset_mem got req=%b addr=%h wstrb=%h exp 0/0/0", mem_bus.req, mem_bus.addr, mem_bus.wstrb); else pass_cnt++;
        next_cyc();
    endtask

    task automatic test_fetch();
        inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_0000;
        to_neg();
        total_cnt++; if (inst_bus.addr_ok !== 1'b1) $display("FAIL fetch_addr_ok got %b exp 1", inst_bus.addr_ok); else pass_cnt++;
        total_cnt++; if (mem_bus.req !== 1'b0) $display("FAIL fetch_latency got mem_req=%b exp 0", mem_bus.req); else pass_cnt++;
        next_cyc();
        inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b1;
        to_neg();
        total_cnt++; if (mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h1C00_0000) $display("FAIL fetch_issue got req=%b addr=%h exp 1/1c000000", mem_bus.req, mem_bus.addr); else pass_cnt++;
        total_cnt++; if (mem_bus.wstrb !== 4'd0 || mem_bus.wr !== 1'b0 || mem_bus.size !== 2'd2) $display("FAIL fetch_payload got wstrb=%h wr=%b size=%0d exp 0/0/2", mem_bus.wstrb, mem_bus.wr, mem_bus.size); else pass_cnt++;
        next_cyc();
        mem_bus.addr_ok = 1'b0;
        to_neg();
        total_cnt++; if (mem_bus.req !== 1'b0) $display("FAIL fetch_req_drop got %b exp 0", mem_bus.req); else pass_cnt++;
        next_cyc();
        mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h0280_0C00;
        to_neg();
        total_cnt++; if (inst_bus.data_ok !== 1'b1 || inst_bus.rdata !== 32'h0280_0C00) $display("FAIL fetch_resp got ok=%b rdata=%h exp 1/02800c00", inst_bus.data_ok, inst_bus.rdata); else pass_cnt++;
        total_cnt++; if (data_bus.data_ok !== 1'b0 || data_bus.rdata !== 32'd0) $display("FAIL fetch_no_data got ok=%b rdata=%h exp 0/0", data_bus.data_ok, data_bus.rdata); else pass_cnt++;
        next_cyc();
        clear_inputs();
        to_neg();
        total_cnt++; if (inst_bus.data_ok !== 1'b0 || inst_bus.rdata !== 32'd0) $display("FAIL fetch_idle got ok=%b rdata=%h exp 0/0", inst_bus.data_ok, inst_bus.rdata); else pass_cnt++;
        next_cyc();
    endtask

    task automatic test_contention();
        inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_0000;
        data_load(32'h0000_1000);
        to_neg();
        total_cnt++; if (data_bus.addr_ok !== 1'b1 || inst_bus.addr_ok !== 1'b0) $display("FAIL cont_priority got data=%b inst=%b exp 1/0", data_bus.addr_ok, inst_bus.addr_ok); else pass_cnt++;
        next_cyc();
        data_bus.req = 1'b0; mem_bus.addr_ok = 1'b1;
        to_neg();
        total_cnt++; if (mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h0000_1000 || mem_bus.wstrb !== 4'd0) $display("FAIL cont_first got req=%b addr=%h wstrb=%h exp 1/00001000/0", mem_bus.req, mem_bus.addr, mem_bus.wstrb); else pass_cnt++;
        total_cnt++; if (inst_bus.addr_ok !== 1'b1) $display("FAIL cont_inst_accept got %b exp 1", inst_bus.addr_ok); else pass_cnt++;
        next_cyc();
        inst_bus.req = 1'b0;
        to_neg();
        total_cnt++; if (mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h1C00_0000) $display("FAIL cont_second got req=%b addr=%h exp 1/1c000000", mem_bus.req, mem_bus.addr); else pass_cnt++;
        next_cyc();
        mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'hAAAA_0001;
        to_neg();
        total_cnt++; if (data_bus.data_ok !== 1'b1 || data_bus.rdata !== 32'hAAAA_0001 || inst_bus.data_ok !== 1'b0) $display("FAIL cont_resp_data got dok=%b rdata=%h iok=%b exp 1/aaaa0001/0", data_bus.data_ok, data_bus.rdata, inst_bus.data_ok); else pass_cnt++;
        next_cyc();
        mem_bus.rdata = 32'hBBBB_0002;
        to_neg();
        total_cnt++; if (inst_bus.data_ok !== 1'b1 || inst_bus.rdata !== 32'hBBBB_0002 || data_bus.data_ok !== 1'b0) $display("FAIL cont_resp_inst got iok=%b rdata=%h dok=%b exp 1/bbbb0002/0", inst_bus.data_ok, inst_bus.rdata, data_bus.data_ok); else pass_cnt++;
        next_cyc();
        mem_bus.rdata = 32'hDEAD_BEEF;
        to_neg();
        total_cnt++; if (inst_bus.data_ok !== 1'b0 || data_bus.data_ok !== 1'b0) $display("FAIL cont_empty_resp got iok=%b dok=%b exp 0/0", inst_bus.data_ok, data_bus.data_ok); else pass_cnt++;
        next_cyc();
        clear_inputs();
    endtask

    task automatic test_byte_store();
        data_bus.req = 1'b1; data_bus.wr = 1'b1; data_bus.size = 2'd0;
        data_bus.wstrb = 4'b0100; data_bus.wdata = 32'h00AB_0000; data_bus.addr = 32'h0000_2002;
        to_neg();
        total_cnt++; if (data_bus.addr_ok !== 1'b1) $display("FAIL store_accept got %b exp 1", data_bus.addr_ok); else pass_cnt++;
        next_cyc();
        clear_inputs();
        mem_bus.addr_ok = 1'b1;
        to_neg();
        total_cnt++; if (mem_bus.req !== 1'b1 || mem_bus.wr !== 1'b1 || mem_bus.size !== 2'd0 || mem_bus.wstrb !== 4'b0100 || mem_bus.addr !== 32'h0000_2002 || mem_bus.wdata !== 32'h00AB_0000)
            $display("FAIL store_payload got req=%b wr=%b size=%0d wstrb=%b addr=%h wdata=%h exp 1/1/0/0100/00002002/00ab0000", mem_bus.req, mem_bus.wr, mem_bus.size, mem_bus.wstrb, mem_bus.addr, mem_bus.wdata);
        else pass_cnt++;
        next_cyc();
        mem_bus.addr_ok = 1'b0;
        next_cyc();
        mem_bus.data_ok = 1'b1;
        to_neg();
        total_cnt++; if (data_bus.data_ok !== 1'b1 || inst_bus.data_ok !== 1'b0) $display("FAIL store_done got dok=%b iok=%b exp 1/0", data_bus.data_ok, inst_bus.data_ok); else pass_cnt++;
        next_cyc();
        clear_inputs();
    endtask

    task automatic test_queue_full();
        mem_bus.addr_ok = 1'b1;
        data_load(32'h100);
        next_cyc();
        data_load(32'h104);
        next_cyc();
        data_load(32'h108);
        next_cyc();
        data_load(32'h10C);
        to_neg();
        total_cnt++; if (mem_bus.req !== 1'b0 || mem_bus.addr !== 32'h108) $display("FAIL full_hold got req=%b addr=%h exp 0/108", mem_bus.req, mem_bus.addr); else pass_cnt++;
        total_cnt++; if (data_bus.addr_ok !== 1'b0) $display("FAIL full_block got %b exp 0", data_bus.addr_ok); else pass_cnt++;
        next_cyc();
        mem_bus.data_ok = 1'b1;
        to_neg();
        total_cnt++; if (mem_bus.req !== 1'b0 || data_bus.data_ok !== 1'b1) $display("FAIL full_pop got req=%b dok=%b exp 0/1", mem_bus.req, data_bus.data_ok); else pass_cnt++;
        next_cyc();
        mem_bus.data_ok = 1'b0;
        to_neg();
        total_cnt++; if (mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h108 || data_bus.addr_ok !== 1'b1) $display("FAIL full_resume got req=%b addr=%h aok=%b exp 1/108/1", mem_bus.req, mem_bus.addr, data_bus.addr_ok); else pass_cnt++;
        next_cyc();
        data_bus.req = 1'b0; mem_bus.data_ok = 1'b1;
        to_neg();
        total_cnt++; if (mem_bus.req !== 1'b0) $display("FAIL full_again got req=%b exp 0", mem_bus.req); else pass_cnt++;
        next_cyc();
        to_neg();
        total_cnt++; if (mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h10C || data_bus.data_ok !== 1'b1) $display("FAIL full_push_pop got req=%b addr=%h dok=%b exp 1/10c/1", mem_bus.req, mem_bus.addr, data_bus.data_ok); else pass_cnt++;
        next_cyc();
        mem_bus.addr_ok = 1'b0;
        to_neg();
        total_cnt++; if (data_bus.data_ok !== 1'b1 || mem_bus.req !== 1'b0) $display("FAIL full_last got dok=%b req=%b exp 1/0", data_bus.data_ok, mem_bus.req); else pass_cnt++;
        next_cyc();
        clear_inputs();
    endtask

    task automatic test_flush();
        mem_bus.addr_ok = 1'b1;
        inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_0000;
        next_cyc();
        inst_bus.addr = 32'h1C00_0004;
        next_cyc();
        inst_bus.addr = 32'h1C00_0008;
        next_cyc();
        inst_bus.req = 1'b0; flush = 1'b1;
        to_neg();
        total_cnt++; if (mem_bus.req !== 1'b0 || mem_bus.addr !== 32'h1C00_0008) $display("FAIL flush_buffered got req=%b addr=%h exp 0/1c000008", mem_bus.req, mem_bus.addr); else pass_cnt++;
        next_cyc();
        flush = 1'b0; mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h1111_1111;
        to_neg();
        total_cnt++; if (inst_bus.data_ok !== 1'b0 || inst_bus.rdata !== 32'd0) $display("FAIL flush_drop0 got ok=%b rdata=%h exp 0/0", inst_bus.data_ok, inst_bus.rdata); else pass_cnt++;
        next_cyc();
        to_neg();
        total_cnt++; if (inst_bus.data_ok !== 1'b0 || mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h1C00_0008) $display("FAIL flush_drop1 got ok=%b req=%b addr=%h exp 0/1/1c000008", inst_bus.data_ok, mem_bus.req, mem_bus.addr); else pass_cnt++;
        next_cyc();
        mem_bus.addr_ok = 1'b0;
        data_load(32'h0000_3000);
        to_neg();
        total_cnt++; if (inst_bus.data_ok !== 1'b0 || data_bus.addr_ok !== 1'b1) $display("FAIL flush_drop2 got iok=%b aok=%b exp 0/1", inst_bus.data_ok, data_bus.addr_ok); else pass_cnt++;
        next_cyc();
        data_bus.req = 1'b0; mem_bus.data_ok = 1'b0; mem_bus.addr_ok = 1'b1;
        next_cyc();
        mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h1234_5678;
        to_neg();
        total_cnt++; if (data_bus.data_ok !== 1'b1 || data_bus.rdata !== 32'h1234_5678) $display("FAIL flush_data_after got ok=%b rdata=%h exp 1/12345678", data_bus.data_ok, data_bus.rdata); else pass_cnt++;
        next_cyc();
        clear_inputs();
        inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_0020;
        next_cyc();
        inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b1;
        next_cyc();
        mem_bus.addr_ok = 1'b0;
        next_cyc();
        flush = 1'b1; mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h5555_AAAA;
        to_neg();
        total_cnt++; if (inst_bus.data_ok !== 1'b0) $display("FAIL flush_same_cycle got %b exp 0", inst_bus.data_ok); else pass_cnt++;
        next_cyc();
        clear_inputs();
        mem_bus.data_ok = 1'b1;
        to_neg();
        total_cnt++; if (inst_bus.data_ok !== 1'b0 || data_bus.data_ok !== 1'b0) $display("FAIL flush_popped got iok=%b dok=%b exp 0/0", inst_bus.data_ok, data_bus.data_ok); else pass_cnt++;
        next_cyc();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        mem_bus.addr_ok = 1'b1;
        data_load(32'h200);
        next_cyc();
        data_load(32'h204);
        next_cyc();
        data_load(32'h208);
        next_cyc();
        data_bus.req = 1'b0; mem_bus.addr_ok = 1'b0; reset = 1'b1;
        next_cyc();
        reset = 1'b0; mem_bus.data_ok = 1'b1;
        to_neg();
        total_cnt++; if (mem_bus.req !== 1'b0 || inst_bus.addr_ok !== 1'b0 || data_bus.addr_ok !== 1'b0) $display("FAIL rmid_idle got req=%b iaok=%b daok=%b exp 0/0/0", mem_bus.req, inst_bus.addr_ok, data_bus.addr_ok); else pass_cnt++;
        total_cnt++; if (data_bus.data_ok !== 1'b0 || inst_bus.data_ok !== 1'b0) $display("FAIL rmid_empty got dok=%b iok=%b exp 0/0", data_bus.data_ok, inst_bus.data_ok); else pass_cnt++;
        next_cyc();
        clear_inputs();
        inst_bus.req = 1'b1; inst_bus.addr = 32'h1C00_0010;
        to_neg();
        total_cnt++; if (inst_bus.addr_ok !== 1'b1) $display("FAIL rmid_fetch_accept got %b exp 1", inst_bus.addr_ok); else pass_cnt++;
        next_cyc();
        inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b1;
        to_neg();
        total_cnt++; if (mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h1C00_0010) $display("FAIL rmid_fetch_issue got req=%b addr=%h exp 1/1c000010", mem_bus.req, mem_bus.addr); else pass_cnt++;
        next_cyc();
        mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h0000_CAFE;
        to_neg();
        total_cnt++; if (inst_bus.data_ok !== 1'b1 || inst_bus.rdata !== 32'h0000_CAFE) $display("FAIL rmid_fetch_resp got ok=%b rdata=%h exp 1/0000cafe", inst_bus.data_ok, inst_bus.rdata); else pass_cnt++;
        next_cyc();
        clear_inputs();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b1;
        clear_inputs();
        next_cyc();
        test_reset();
        test_fetch();
        test_contention();
        test_byte_store();
        test_queue_full();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
